// File: rtl/multipumped_pkg.sv
// Shared constants and helpers for the round-robin multipumped memory.
package multipumped_pkg;

  // Cycles from request acceptance to q_valid.
  localparam int READ_LATENCY = 2;

  // Upper bound on request ports handled by rr_pick.
  localparam int MAX_PORTS = 64;
  localparam int IDX_W     = 7;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Number of bits needed to represent value (at least 1).
  function automatic int log2(input int value);
    int v;
    int bits;
    v    = value;
    bits = 0;
    while (v > 0) begin
      bits = bits + 1;
      v    = v >> 1;
    end
    if (bits == 0) bits = 1;
    return bits;
  endfunction

  // First requesting port scanning ptr, ptr+1, ... (mod ports), ignoring skip.
  function automatic pick_t rr_pick(input logic [MAX_PORTS-1:0] req,
                                    input int ptr, input int ports, input int skip);
    pick_t r;
    int    i;
    r = '0;
    for (int k = 0; k < MAX_PORTS; k++) begin
      if (k < ports) begin
        i = ptr + k;
        if (i >= ports) i = i - ports;
        if (!r.found && req[i] && (i != skip)) begin
          r.found = 1'b1;
          r.idx   = IDX_W'(i);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dual_port_block_ram.sv
// Synchronous-read dual-port RAM, one-cycle read latency, no reset on contents.
module dual_port_block_ram #(
  parameter int WIDTH      = 64,
  parameter int DEPTH      = 512,
  parameter int LOG2_DEPTH = 9
) (
  input  logic                  clk,
  input  logic                  en_a,
  input  logic                  we_a,
  input  logic [LOG2_DEPTH-1:0] addr_a,
  input  logic [WIDTH-1:0]      din_a,
  output logic [WIDTH-1:0]      dout_a,
  input  logic                  en_b,
  input  logic                  we_b,
  input  logic [LOG2_DEPTH-1:0] addr_b,
  input  logic [WIDTH-1:0]      din_b,
  output logic [WIDTH-1:0]      dout_b
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Both ports in one block; the caller guarantees no same-address write collision.
  always_ff @(posedge clk) begin
    if (en_a) begin
      if (we_a) mem[addr_a] <= din_a;
      else      dout_a      <= mem[addr_a];
    end
    if (en_b) begin
      if (we_b) mem[addr_b] <= din_b;
      else      dout_b      <= mem[addr_b];
    end
  end

endmodule

// File: rtl/multipumped_memory_rr.sv
// Round-robin front end granting up to two port requests per cycle onto one
// dual-port RAM, with reads steered back to the requesting port.
module multipumped_memory_rr
  import multipumped_pkg::*;
#(
  parameter int PORTS      = 8,
  parameter int WIDTH      = 64,
  parameter int DEPTH      = 512,
  parameter int LOG2_DEPTH = log2(DEPTH - 1),
  parameter int LOG2_PORTS = log2(PORTS - 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PORTS-1:0]            req,
  input  logic [PORTS-1:0]            wr,
  input  logic [PORTS*LOG2_DEPTH-1:0] addr,
  input  logic [PORTS*WIDTH-1:0]      d,
  output logic [PORTS-1:0]            gnt,
  output logic [PORTS*WIDTH-1:0]      q,
  output logic [PORTS-1:0]            q_valid
);

  // Handshake: port i holds req[i] (with wr/addr/d stable) until it sees
  // gnt[i]; the request is accepted in the cycle where req[i] && gnt[i].
  // gnt is combinational from req/wr/addr and the round-robin pointer.
  // A read accepted in cycle T returns with a one-cycle q_valid[i] pulse in
  // cycle T+2; q slice i then holds until that port's next read return.

  logic [LOG2_PORTS-1:0] ptr;
  logic [MAX_PORTS-1:0]  req_ext;
  pick_t                 pick_a, pick_b;
  logic                  a_go, b_go, a_wr, b_wr;
  logic [LOG2_PORTS-1:0] a_idx, b_idx;
  logic [LOG2_DEPTH-1:0] a_addr, b_addr;
  logic [WIDTH-1:0]      a_din, b_din, a_dout, b_dout;
  logic                  s1_va, s1_vb;
  logic [LOG2_PORTS-1:0] s1_pa, s1_pb;
  logic [PORTS*WIDTH-1:0] q_r;
  logic [PORTS-1:0]      q_valid_r;

  function automatic logic [LOG2_PORTS-1:0] wrap_inc(input logic [LOG2_PORTS-1:0] i);
    return (i == LOG2_PORTS'(PORTS - 1)) ? '0 : i + LOG2_PORTS'(1);
  endfunction

  // Slot selection: A is the first requester from ptr, B the next one, with B
  // dropped when it would touch A's address and either side writes.
  always_comb begin
    req_ext            = '0;
    req_ext[PORTS-1:0] = req;
    pick_a = rr_pick(req_ext, int'(ptr), PORTS, -1);
    pick_b = rr_pick(req_ext, int'(ptr), PORTS, int'(pick_a.idx));
    a_idx  = LOG2_PORTS'(pick_a.idx);
    b_idx  = LOG2_PORTS'(pick_b.idx);
    a_wr   = wr[a_idx];
    b_wr   = wr[b_idx];
    a_addr = addr[int'(a_idx)*LOG2_DEPTH +: LOG2_DEPTH];
    b_addr = addr[int'(b_idx)*LOG2_DEPTH +: LOG2_DEPTH];
    a_din  = d[int'(a_idx)*WIDTH +: WIDTH];
    b_din  = d[int'(b_idx)*WIDTH +: WIDTH];
    a_go   = rst_n && pick_a.found;
    b_go   = a_go && pick_b.found && !((a_addr == b_addr) && (a_wr || b_wr));
    gnt    = '0;
    if (a_go) gnt[a_idx] = 1'b1;
    if (b_go) gnt[b_idx] = 1'b1;
  end

  // Pointer moves just past the last port granted this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ptr <= '0;
    else if (b_go) ptr <= wrap_inc(b_idx);
    else if (a_go) ptr <= wrap_inc(a_idx);
  end

  // First return stage: remembers which port each RAM read belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_va <= 1'b0;
      s1_vb <= 1'b0;
      s1_pa <= '0;
      s1_pb <= '0;
    end else begin
      s1_va <= a_go && !a_wr;
      s1_vb <= b_go && !b_wr;
      s1_pa <= a_idx;
      s1_pb <= b_idx;
    end
  end

  // Second return stage: steer RAM data into the owning port's q slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r       <= '0;
      q_valid_r <= '0;
    end else begin
      q_valid_r <= '0;
      if (s1_va) begin
        q_r[int'(s1_pa)*WIDTH +: WIDTH] <= a_dout;
        q_valid_r[s1_pa]                <= 1'b1;
      end
      if (s1_vb) begin
        q_r[int'(s1_pb)*WIDTH +: WIDTH] <= b_dout;
        q_valid_r[s1_pb]                <= 1'b1;
      end
    end
  end

  assign q       = q_r;
  assign q_valid = q_valid_r;

  dual_port_block_ram #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .LOG2_DEPTH(LOG2_DEPTH)
  ) u_ram (
    .clk   (clk),
    .en_a  (a_go),
    .we_a  (a_go && a_wr),
    .addr_a(a_addr),
    .din_a (a_din),
    .dout_a(a_dout),
    .en_b  (b_go),
    .we_b  (b_go && b_wr),
    .addr_b(b_addr),
    .din_b (b_din),
    .dout_b(b_dout)
  );

endmodule
